// File: rtl/apu_reg_loader.sv
// rtl/apu_reg_loader.sv - UART-fed (address, data) writer for the 32 x 8-bit APU register bank
// Bytes with bits[7:5]=0 select an address; the next byte is written there unless it times out or misframes.
module apu_reg_loader #(
   parameter int BAUD_DIV     = 93,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx,
   output logic [255:0] reg_flat,
   output logic         wr_strobe,
   output logic [4:0]   wr_addr,
   output logic         frame_err
);

   localparam logic [7:0] HALF_M1  = 8'(BAUD_DIV / 2 - 1);
   localparam logic [7:0] FULL_M1  = 8'(BAUD_DIV - 1);
   localparam int         TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
   localparam int         TW       = $clog2(TO_LIMIT + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {DEC_ADDR, DEC_DATA} dec_state_t;

   logic       sync1, rx_s, rx_prev;
   rx_state_t  rx_q, rx_n;
   logic [7:0] baud_q, baud_n;
   logic [2:0] bit_q, bit_n;
   logic [7:0] shift_q, shift_n;
   logic       byte_ok, byte_bad;

   dec_state_t   dec_q, dec_n;
   logic [4:0]   addr_q, addr_n;
   logic [TW-1:0] to_q, to_n;
   logic         we;

   // Synchronizer and edge history idle high so reset release never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q    <= RX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         rx_q    <= rx_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         shift_q <= shift_n;
      end
   end

   always_comb begin
      rx_n     = rx_q;
      baud_n   = baud_q + 8'd1;
      bit_n    = bit_q;
      shift_n  = shift_q;
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
      case (rx_q)
         RX_IDLE: begin
            baud_n = '0;
            if (rx_prev && !rx_s) begin
               rx_n  = RX_START;
               bit_n = '0;
            end
         end
         RX_START: begin
            if (baud_q == HALF_M1) begin
               baud_n = '0;
               rx_n   = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_q == FULL_M1) begin
               baud_n  = '0;
               shift_n = {rx_s, shift_q[7:1]};
               bit_n   = bit_q + 3'd1;
               if (bit_q == 3'd7) rx_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (baud_q == FULL_M1) begin
               baud_n   = '0;
               rx_n     = RX_IDLE;
               byte_ok  = rx_s;
               byte_bad = !rx_s;
            end
         end
         default: rx_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q     <= DEC_ADDR;
         addr_q    <= '0;
         to_q      <= '0;
         reg_flat  <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         dec_q     <= dec_n;
         addr_q    <= addr_n;
         to_q      <= to_n;
         wr_strobe <= we;
         frame_err <= byte_bad;
         if (we) begin
            reg_flat[{addr_q, 3'b000} +: 8] <= shift_q;
            wr_addr                         <= addr_q;
         end
      end
   end

   // Timeout only advances while the line is idle; an in-flight byte freezes it
   always_comb begin
      dec_n  = dec_q;
      addr_n = addr_q;
      to_n   = to_q;
      we     = 1'b0;
      case (dec_q)
         DEC_ADDR: begin
            to_n = '0;
            if (byte_ok && shift_q[7:5] == 3'b000) begin
               addr_n = shift_q[4:0];
               dec_n  = DEC_DATA;
            end
         end
         DEC_DATA: begin
            if (byte_bad) begin
               dec_n = DEC_ADDR;
            end else if (byte_ok) begin
               we    = 1'b1;
               dec_n = DEC_ADDR;
            end else if (rx_q == RX_IDLE) begin
               if (to_q == TW'(TO_LIMIT - 1)) dec_n = DEC_ADDR;
               else                           to_n  = to_q + TW'(1);
            end
         end
         default: dec_n = DEC_ADDR;
      endcase
   end

endmodule

// File: tb/tb_apu_reg_loader.sv
// tb/tb_apu_reg_loader.sv - directed UART vectors against apu_reg_loader
// Expected register contents are kept in a bench-side array set by hand per vector.
module tb_apu_reg_loader;

   localparam int BD = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx = 1'b1;
   logic [255:0] reg_flat;
   logic         wr_strobe;
   logic [4:0]   wr_addr;
   logic         frame_err;

   logic [7:0] exp_reg [32];
   int n_vec = 0, n_bad = 0;
   int cyc = 0, n_strobe = 0, n_ferr = 0, last_strobe_cyc = 0;
   int s0, f0, c0;

   apu_reg_loader #(.BAUD_DIV(BD), .TIMEOUT_BITS(20)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .reg_flat  (reg_flat),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_strobe) begin
         n_strobe++;
         last_strobe_cyc = cyc;
      end
      if (frame_err) n_ferr++;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   function automatic logic [255:0] exp_flat();
      logic [255:0] f;
      for (int i = 0; i < 32; i++) f[i*8 +: 8] = exp_reg[i];
      return f;
   endfunction

   task automatic send(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BD) @(negedge clk);
      end
      rx = stop;
      repeat (BD) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) exp_reg[i] = 8'h00;

      // reset held while rx toggles
      repeat (3) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         rx = i[0];
         @(negedge clk);
      end
      rx = 1'b1;
      check("reset_regs", reg_flat, 256'h0);
      check("reset_strobe", {255'h0, wr_strobe}, 256'h0);
      check("reset_ferr", {255'h0, frame_err}, 256'h0);
      check("reset_addr", {251'h0, wr_addr}, 256'h0);
      check("reset_events", n_strobe + n_ferr, 256'h0);
      rst_n = 1'b1;
      idle(40);
      check("post_reset_regs", reg_flat, 256'h0);
      check("post_reset_events", n_strobe + n_ferr, 256'h0);

      // single write with strobe timing window
      s0 = n_strobe;
      send(8'h00, 1'b1);
      c0 = cyc;
      send(8'hBF, 1'b1);
      idle(20);
      exp_reg[0] = 8'hBF;
      check("single_count", n_strobe - s0, 1);
      check("single_addr", {251'h0, wr_addr}, 256'h0);
      check("single_regs", reg_flat, exp_flat());
      check("single_timing", (last_strobe_cyc - c0 >= 152 && last_strobe_cyc - c0 <= 158), 1);

      // back-to-back pairs without idle gap
      s0 = n_strobe;
      send(8'h03, 1'b1);
      send(8'h08, 1'b1);
      send(8'h1F, 1'b1);
      send(8'hFF, 1'b1);
      idle(20);
      exp_reg[3]  = 8'h08;
      exp_reg[31] = 8'hFF;
      check("b2b_count", n_strobe - s0, 2);
      check("b2b_addr", {251'h0, wr_addr}, 256'd31);
      check("b2b_regs", reg_flat, exp_flat());

      // non-address byte ignored; data byte in address range still written as data
      s0 = n_strobe;
      send(8'h20, 1'b1);
      send(8'h01, 1'b1);
      send(8'h05, 1'b1);
      idle(20);
      exp_reg[1] = 8'h05;
      check("badaddr_count", n_strobe - s0, 1);
      check("badaddr_addr", {251'h0, wr_addr}, 256'd1);
      check("badaddr_regs", reg_flat, exp_flat());

      // framing error drops the pending write
      s0 = n_strobe;
      f0 = n_ferr;
      send(8'h02, 1'b1);
      send(8'h99, 1'b0);
      idle(20);
      check("ferr_pulse", n_ferr - f0, 1);
      check("ferr_nowrite", n_strobe - s0, 0);
      check("ferr_regs", reg_flat, exp_flat());
      send(8'h02, 1'b1);
      send(8'h44, 1'b1);
      idle(20);
      exp_reg[2] = 8'h44;
      check("ferr_recover_count", n_strobe - s0, 1);
      check("ferr_recover_regs", reg_flat, exp_flat());

      // timeout: the late byte becomes a new address
      s0 = n_strobe;
      send(8'h04, 1'b1);
      idle(21 * BD);
      send(8'h10, 1'b1);
      idle(20);
      check("timeout_nowrite", n_strobe - s0, 0);
      check("timeout_regs", reg_flat, exp_flat());
      send(8'h77, 1'b1);
      idle(20);
      exp_reg[16] = 8'h77;
      check("timeout_newaddr_count", n_strobe - s0, 1);
      check("timeout_newaddr", {251'h0, wr_addr}, 256'd16);
      check("timeout_newaddr_regs", reg_flat, exp_flat());

      // short low glitch in idle
      s0 = n_strobe;
      f0 = n_ferr;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(40);
      check("glitch_events", (n_strobe - s0) + (n_ferr - f0), 0);
      send(8'h05, 1'b1);
      send(8'h5A, 1'b1);
      idle(20);
      exp_reg[5] = 8'h5A;
      check("glitch_recover_count", n_strobe - s0, 1);
      check("glitch_recover_regs", reg_flat, exp_flat());

      // reset mid-frame discards latched address and clears the bank
      send(8'h06, 1'b1);
      rx = 1'b0;
      idle(30);
      rst_n = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(3);
      for (int i = 0; i < 32; i++) exp_reg[i] = 8'h00;
      check("midreset_regs", reg_flat, 256'h0);
      rst_n = 1'b1;
      idle(20);
      s0 = n_strobe;
      send(8'h09, 1'b1);
      idle(20);
      check("midreset_noaddr", n_strobe - s0, 0);
      send(8'h33, 1'b1);
      idle(20);
      exp_reg[9] = 8'h33;
      check("midreset_write_count", n_strobe - s0, 1);
      check("midreset_write_regs", reg_flat, exp_flat());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
